// File: rtl/wave_sequencer_pkg.sv
// Shared definitions for the waveform sequencer: address width, wave
// select codes, sequencer state encoding and a small state decode helper.
package wavegen_pkg;

    localparam int ADDR_W = 9;

    localparam logic [1:0] WAVE_SINE = 2'b00;
    localparam logic [1:0] WAVE_TRI  = 2'b01;
    localparam logic [1:0] WAVE_SQR  = 2'b10;
    localparam logic [1:0] WAVE_PWM  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PEND  = 2'b10,
        DRAIN = 2'b11
    } seq_state_t;

    // New settings can only be taken while nothing is already staged and
    // the sequencer is not winding down.
    function automatic logic accepts_cfg(input seq_state_t st);
        return (st == IDLE) || (st == RUN);
    endfunction

endpackage

// File: rtl/phase_accumulator.sv
// DDS phase accumulator: adds the increment each enabled cycle, reports the
// carry out of the add (the period wrap) and exposes the table address.
module phase_accumulator
    import wavegen_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    input  logic [ACC_W-1:0]  incr,
    output logic              wrap,
    output logic [ADDR_W-1:0] address
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    assign sum     = {1'b0, acc} + {1'b0, incr};
    assign wrap    = sum[ACC_W];
    assign address = acc[ACC_W-1 -: ADDR_W];

    // Phase register: clear has priority so a stop lands exactly on zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= {ACC_W{1'b0}};
        end else if (clear) begin
            acc <= {ACC_W{1'b0}};
        end else if (step) begin
            acc <= sum[ACC_W-1:0];
        end else begin
            acc <= acc;
        end
    end

endmodule

// File: rtl/wave_sequencer.sv
// Sequencer in front of the waveform shaping stage. Owns the phase
// accumulator, gates the shaping enable and holds the active wave, PWM and
// frequency settings. New settings and start/stop only take effect on a
// period boundary so the generated waveform never glitches mid-cycle.
module wave_sequencer
    import wavegen_pkg::*;
#(
    parameter int         ACC_W   = 24,
    parameter logic [6:0] RST_PWM = 7'd64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_wave_word,
    input  logic [6:0]        cfg_pwm_word,
    input  logic [ACC_W-1:0]  cfg_freq_word,
    output logic              enable,
    output logic [1:0]        wave_word,
    output logic [6:0]        pwm_word,
    output logic [ADDR_W-1:0] address,
    output logic              period_tick,
    output logic              cfg_pending
);

    seq_state_t       state;
    logic [ACC_W-1:0] freq;
    logic [1:0]       staged_wave;
    logic [6:0]       staged_pwm;
    logic [ACC_W-1:0] staged_freq;

    logic acc_clear;
    logic acc_step;
    logic acc_wrap;
    logic wrap_eff;
    logic freq_zero;
    logic xfer;

    assign cfg_ready = accepts_cfg(state);
    assign xfer      = cfg_valid & cfg_ready;
    assign freq_zero = (freq == {ACC_W{1'b0}});

    phase_accumulator #(
        .ACC_W (ACC_W)
    ) u_phase (
        .clk     (clk),
        .rst     (rst),
        .clear   (acc_clear),
        .step    (acc_step),
        .incr    (freq),
        .wrap    (acc_wrap),
        .address (address)
    );

    // Accumulator control and effective wrap; a zero increment counts as an
    // immediate wrap while waiting on a boundary so PEND/DRAIN cannot stall.
    always_comb begin
        acc_clear = 1'b0;
        acc_step  = 1'b0;
        wrap_eff  = 1'b0;
        case (state)
            IDLE: begin
                acc_clear = 1'b1;
            end
            RUN: begin
                acc_step = 1'b1;
                wrap_eff = acc_wrap;
            end
            PEND: begin
                acc_step = 1'b1;
                wrap_eff = acc_wrap | freq_zero;
            end
            DRAIN: begin
                acc_step  = 1'b1;
                wrap_eff  = acc_wrap | freq_zero;
                acc_clear = acc_wrap | freq_zero;
            end
            default: begin
                acc_clear = 1'b1;
            end
        endcase
    end

    // Sequencer FSM with registered enable, settings, tick and pending flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            enable      <= 1'b0;
            wave_word   <= 2'b00;
            pwm_word    <= RST_PWM;
            freq        <= {ACC_W{1'b0}};
            period_tick <= 1'b0;
            cfg_pending <= 1'b0;
            staged_wave <= 2'b00;
            staged_pwm  <= 7'd0;
            staged_freq <= {ACC_W{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    period_tick <= 1'b0;
                    if (xfer) begin
                        wave_word <= cfg_wave_word;
                        pwm_word  <= cfg_pwm_word;
                        freq      <= cfg_freq_word;
                    end
                    if (run) begin
                        state  <= RUN;
                        enable <= 1'b1;
                    end else begin
                        enable <= 1'b0;
                    end
                end
                RUN: begin
                    period_tick <= wrap_eff;
                    if (xfer) begin
                        staged_wave <= cfg_wave_word;
                        staged_pwm  <= cfg_pwm_word;
                        staged_freq <= cfg_freq_word;
                        cfg_pending <= 1'b1;
                    end
                    if (!run) begin
                        state <= DRAIN;
                    end else if (xfer) begin
                        state <= PEND;
                    end else begin
                        state <= RUN;
                    end
                end
                PEND: begin
                    period_tick <= wrap_eff;
                    if (wrap_eff) begin
                        wave_word   <= staged_wave;
                        pwm_word    <= staged_pwm;
                        freq        <= staged_freq;
                        cfg_pending <= 1'b0;
                        state       <= RUN;
                    end else if (!run) begin
                        state <= DRAIN;
                    end else begin
                        state <= PEND;
                    end
                end
                DRAIN: begin
                    period_tick <= wrap_eff;
                    if (wrap_eff) begin
                        enable <= 1'b0;
                        state  <= IDLE;
                        if (cfg_pending) begin
                            wave_word   <= staged_wave;
                            pwm_word    <= staged_pwm;
                            freq        <= staged_freq;
                            cfg_pending <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    enable      <= 1'b0;
                    period_tick <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/wave_sequencer.md
Name: wave_sequencer

Overview:
- Sequencer in front of the waveform lookup/shaping stage.
- Owns the DDS phase accumulator that produces the 9-bit table address.
- Gates the shaping stage's enable and holds the active wave select, PWM duty and frequency word.
- Accepts new settings from the front-panel/UART config path over a valid/ready handshake, and applies them only at a period boundary (address wrap) so the output never glitches mid-cycle. Start/stop is also aligned to the period boundary.

Parameters:
- ACC_W, 24, phase accumulator width; address = acc[ACC_W-1 -: 9]; must be >= 10
- RST_PWM, 7'd64, pwm_word value after reset (50% duty)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = generate, 0 = stop at next period end
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  sequencer can accept configuration this cycle
- cfg_wave_word  in  2  00 sine, 01 triangle, 10 square, 11 PWM
- cfg_pwm_word  in  7  PWM threshold (compared against address/4 downstream)
- cfg_freq_word  in  ACC_W  phase increment per clk
- enable  out  1  to shaping stage
- wave_word  out  2  active wave select
- pwm_word  out  7  active PWM threshold
- address  out  9  phase address
- period_tick  out  1  one-cycle pulse on each wrap
- cfg_pending  out  1  staged config waiting for wrap

Behaviour:
- Reset (async, immediate): state=IDLE, acc=0, enable=0, wave_word=0, pwm_word=RST_PWM, freq=0, period_tick=0, cfg_pending=0, staged regs=0.
- All outputs are registered.
- address is acc's top 9 bits, valid the cycle after the acc update. The shaping stage adds one more cycle, so waveform lags address by 1 clk.
- Handshake: transfer when cfg_valid & cfg_ready on a rising edge. cfg_ready=1 in IDLE and RUN, 0 in PEND and DRAIN. cfg_ready is combinational from state only; it never depends on cfg_valid.
- Wrap: carry out of acc+freq (ACC_W+1 bit sum). If freq==0, wrap is treated as immediate in PEND/DRAIN so neither state can hang. In RUN with freq==0, acc holds and no tick is produced.
- IDLE:
  - acc=0, enable=0.
  - A config transfer loads the active regs directly on the next edge.
  - run=1 -> RUN; enable=1 on the same edge; acc starts from 0.
  - A config transfer and run=1 in the same cycle: both take effect on that edge.
- RUN:
  - acc <= acc+freq (mod 2^ACC_W); period_tick=1 on wrap.
  - A config transfer stages the config and moves to PEND (cfg_pending=1).
  - run=0 -> DRAIN. If run=0 and a config transfer occur together: stage the config and go to DRAIN.
- PEND:
  - Keep accumulating with the old config.
  - On wrap, on the same edge: load staged wave/pwm/freq into the active regs, acc <= wrapped remainder (phase continuous), cfg_pending=0, return to RUN.
  - run=0 -> DRAIN; staging is kept.
- DRAIN:
  - Keep accumulating until wrap.
  - On wrap: acc=0, enable=0, period_tick=1, apply any staged config, cfg_pending=0, go to IDLE.
  - run returning to 1 during DRAIN is ignored until IDLE is reached.
- wave_word, pwm_word and freq change only in IDLE or at a wrap edge.
- rst mid-period: immediate return to reset values; staged config is discarded.

Decomposition:
- Package wavegen_pkg:
  - ADDR_W=9
  - wave codes WAVE_SINE=2'b00, WAVE_TRI=2'b01, WAVE_SQR=2'b10, WAVE_PWM=2'b11
  - state encoding IDLE/RUN/PEND/DRAIN (2 bits)
- Sub-module phase_accumulator:
  - ACC_W register with clear, step enable and increment input.
  - Outputs acc, carry/wrap flag and address slice.
  - The sequencer FSM instantiates one.

Test Plan (ACC_W=12, so address=acc[11:3]):
1. Reset; cfg {sine, pwm 64, freq 8} in IDLE; run=1 -> address increments by 1 per clk; period_tick every 512 clk; enable=1 one clk after run.
2. In RUN at address 100, cfg {square, freq 16} -> cfg_ready=0 and cfg_pending=1 until address 511->0. Then wave_word=10 and address steps by 2 from the same edge; pending clears.
3. freq 24 (step 3) running, run=0 at address 200 -> address continues to wrap; enable=0 and address=0 at the wrap; period_tick pulses once; FSM in IDLE; cfg_ready=1.
4. freq=0 in RUN, offer a cfg -> PEND resolves on the next clk (immediate wrap); new config active; no hang.
5. Assert rst asynchronously mid-period in PEND -> enable=0, address=0, pwm_word=64, cfg_pending=0 without waiting for clk; the staged config is never applied.
6. run=0 and cfg_valid in the same RUN cycle with cfg {PWM, pwm 32, freq 8} -> DRAIN; at wrap IDLE with wave_word=11, pwm_word=32.
